// File: rtl/floor_request_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : floor_request_unit
// Purpose  : Debounced floor-request capture into a one-hot pending register,
//            with service clearing and above/below/here direction hints.
// Revision : 1.0 - initial release
// ============================================================================
module floor_request_unit #(
    parameter int NUM_FLOORS      = 10,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic                  CLOCK_50,
    input  logic                  rst,
    input  logic                  key_n,
    input  logic [3:0]            floor_sel,
    input  logic [NUM_FLOORS-1:0] cur_floor,
    input  logic                  service_done,
    output logic [NUM_FLOORS-1:0] floor_reg,
    output logic                  req_accept,
    output logic                  req_reject,
    output logic                  any_request,
    output logic                  req_here,
    output logic                  req_above,
    output logic                  req_below
);

    localparam int                    CW     = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0]         DB_MAX = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [NUM_FLOORS-1:0] ONE    = NUM_FLOORS'(1);

    logic                  key_meta_q, key_s_q;
    logic [3:0]            sel_meta_q, sel_s_q;
    logic                  key_stable_q, key_stable_d;
    logic                  key_stable_prev_q;
    logic [CW-1:0]         db_cnt_q, db_cnt_d;
    logic                  svc_prev_q;
    logic [NUM_FLOORS-1:0] floor_q, floor_d;
    logic                  accept_q, accept_d;
    logic                  reject_q, reject_d;

    logic                  w_press;
    logic                  w_sel_valid;
    logic                  w_svc_rise;
    logic                  w_cur_onehot;
    logic [NUM_FLOORS-1:0] w_set_mask;
    logic [NUM_FLOORS-1:0] w_clear_mask;
    logic [NUM_FLOORS-1:0] w_below_mask;
    logic [NUM_FLOORS-1:0] w_above_mask;

    always_comb begin
        key_stable_d = key_stable_q;
        db_cnt_d     = '0;
        if (key_s_q != key_stable_q) begin
            if (db_cnt_q == DB_MAX) begin
                key_stable_d = key_s_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    // A press is the registered falling edge of the debounced level, so the
    // request lands one cycle after key_stable drops; release is ignored.
    assign w_press      = key_stable_prev_q & ~key_stable_q;
    assign w_sel_valid  = (sel_s_q != 4'd0) && (int'(sel_s_q) <= NUM_FLOORS);
    assign w_svc_rise   = service_done & ~svc_prev_q;
    assign w_cur_onehot = (cur_floor != '0) && ((cur_floor & (cur_floor - ONE)) == '0);

    always_comb begin
        w_set_mask = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            w_set_mask[i] = w_press && w_sel_valid && (sel_s_q == 4'(i + 1));
        end
    end

    assign w_clear_mask = (w_svc_rise && w_cur_onehot) ? cur_floor : '0;

    // Set is applied after clear so a coincident request on the serviced floor survives.
    always_comb begin
        floor_d  = (floor_q & ~w_clear_mask) | w_set_mask;
        accept_d = w_press & w_sel_valid;
        reject_d = w_press & ~w_sel_valid;
    end

    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            key_meta_q        <= 1'b1;
            key_s_q           <= 1'b1;
            sel_meta_q        <= 4'd0;
            sel_s_q           <= 4'd0;
            key_stable_q      <= 1'b1;
            key_stable_prev_q <= 1'b1;
            db_cnt_q          <= '0;
            svc_prev_q        <= 1'b0;
            floor_q           <= '0;
            accept_q          <= 1'b0;
            reject_q          <= 1'b0;
        end else begin
            key_meta_q        <= key_n;
            key_s_q           <= key_meta_q;
            sel_meta_q        <= floor_sel;
            sel_s_q           <= sel_meta_q;
            key_stable_q      <= key_stable_d;
            key_stable_prev_q <= key_stable_q;
            db_cnt_q          <= db_cnt_d;
            svc_prev_q        <= service_done;
            floor_q           <= floor_d;
            accept_q          <= accept_d;
            reject_q          <= reject_d;
        end
    end

    // For a one-hot position, pos-1 marks every lower floor.
    assign w_below_mask = cur_floor - ONE;
    assign w_above_mask = ~(cur_floor | w_below_mask);

    assign floor_reg   = floor_q;
    assign req_accept  = accept_q;
    assign req_reject  = reject_q;
    assign any_request = |floor_q;
    assign req_here    = w_cur_onehot && ((floor_q & cur_floor) != '0);
    assign req_above   = w_cur_onehot && ((floor_q & w_above_mask) != '0);
    assign req_below   = w_cur_onehot && ((floor_q & w_below_mask) != '0);

endmodule
`default_nettype wire

// File: tb/tb_floor_request_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_floor_request_unit
// Purpose  : Scoreboard bench for floor_request_unit with a floor-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_floor_request_unit;

    localparam int NF  = 10;
    localparam int DB  = 4;
    localparam int LAT = 7;

    logic          CLOCK_50 = 1'b0;
    logic          rst = 1'b1;
    logic          key_n = 1'b1;
    logic [3:0]    floor_sel = 4'd0;
    logic [NF-1:0] cur_floor = '0;
    logic          service_done = 1'b0;
    logic [NF-1:0] floor_reg;
    logic          req_accept, req_reject, any_request;
    logic          req_here, req_above, req_below;

    floor_request_unit #(.NUM_FLOORS(NF), .DEBOUNCE_CYCLES(DB)) dut (
        .CLOCK_50     (CLOCK_50),
        .rst          (rst),
        .key_n        (key_n),
        .floor_sel    (floor_sel),
        .cur_floor    (cur_floor),
        .service_done (service_done),
        .floor_reg    (floor_reg),
        .req_accept   (req_accept),
        .req_reject   (req_reject),
        .any_request  (any_request),
        .req_here     (req_here),
        .req_above    (req_above),
        .req_below    (req_below)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int cyc = 0;
    always @(posedge CLOCK_50) cyc <= cyc + 1;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        int cyc;
        bit acc;
        int fl;
    } exp_t;
    exp_t q[$];
    bit   pending[NF];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [NF-1:0] model_vec();
        logic [NF-1:0] v = '0;
        for (int i = 0; i < NF; i++) v[i] = pending[i];
        return v;
    endfunction

    function automatic bit is_onehot(input logic [NF-1:0] v);
        int n = 0;
        for (int i = 0; i < NF; i++) if (v[i]) n++;
        return n == 1;
    endfunction

    // A serviced floor is forgotten when the door cycle starts (applied before any coincident request).
    task automatic model_service(input logic [NF-1:0] cur);
        if (is_onehot(cur))
            for (int i = 0; i < NF; i++) if (cur[i]) pending[i] = 1'b0;
    endtask

    // Monitor: every pulse must match the next expected request event.
    initial begin
        forever begin
            @(posedge CLOCK_50);
            #1;
            if (req_accept === 1'b1 || req_reject === 1'b1) begin
                if (q.size() == 0) begin
                    chk("unexpected_pulse", {30'd0, req_accept, req_reject}, 32'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("pulse_cycle", cyc, e.cyc);
                    chk("pulse_kind", {30'd0, req_accept, req_reject}, e.acc ? 32'd2 : 32'd1);
                    if (e.acc) pending[e.fl-1] = 1'b1;
                    chk("floor_reg_at_pulse", {22'd0, floor_reg}, {22'd0, model_vec()});
                end
            end
        end
    end

    task automatic push_press(input int sel);
        exp_t e;
        e.cyc = cyc + LAT;
        e.acc = (sel >= 1 && sel <= NF);
        e.fl  = sel;
        q.push_back(e);
    endtask

    task automatic press(input int sel, input int hold);
        @(negedge CLOCK_50);
        floor_sel = 4'(sel);
        repeat (3) @(negedge CLOCK_50);
        key_n = 1'b0;
        push_press(sel);
        repeat (hold) @(negedge CLOCK_50);
        key_n = 1'b1;
        repeat (DB + 6) @(negedge CLOCK_50);
    endtask

    task automatic glitch(input int len);
        @(negedge CLOCK_50);
        key_n = 1'b0;
        repeat (len) @(negedge CLOCK_50);
        key_n = 1'b1;
        repeat (DB + 6) @(negedge CLOCK_50);
    endtask

    task automatic service(input logic [NF-1:0] cur, input int hold);
        @(negedge CLOCK_50);
        cur_floor    = cur;
        service_done = 1'b1;
        model_service(cur);
        @(posedge CLOCK_50);
        #1;
        chk("floor_reg_after_clear", {22'd0, floor_reg}, {22'd0, model_vec()});
        repeat (hold) @(negedge CLOCK_50);
        chk("floor_reg_service_held", {22'd0, floor_reg}, {22'd0, model_vec()});
        service_done = 1'b0;
        @(negedge CLOCK_50);
    endtask

    task automatic check_hints(input logic [NF-1:0] cur);
        int  idx = -1;
        bit  any = 0, here = 0, above = 0, below = 0;
        @(negedge CLOCK_50);
        cur_floor = cur;
        #1;
        for (int i = 0; i < NF; i++) begin
            any = any | pending[i];
            if (cur[i]) idx = i;
        end
        if (is_onehot(cur)) begin
            here = pending[idx];
            for (int j = 0; j < NF; j++) begin
                if (j > idx && pending[j]) above = 1;
                if (j < idx && pending[j]) below = 1;
            end
        end
        chk("floor_reg", {22'd0, floor_reg}, {22'd0, model_vec()});
        chk("any_request", {31'd0, any_request}, {31'd0, any});
        chk("req_here", {31'd0, req_here}, {31'd0, here});
        chk("req_above", {31'd0, req_above}, {31'd0, above});
        chk("req_below", {31'd0, req_below}, {31'd0, below});
    endtask

    // Request whose detection edge coincides with a service_done rising edge.
    task automatic aligned(input int sel, input logic [NF-1:0] cur);
        @(negedge CLOCK_50);
        floor_sel = 4'(sel);
        repeat (3) @(negedge CLOCK_50);
        key_n = 1'b0;
        push_press(sel);
        repeat (LAT - 1) @(negedge CLOCK_50);
        cur_floor    = cur;
        service_done = 1'b1;
        model_service(cur);
        @(posedge CLOCK_50);
        #2;
        chk("aligned_floor_reg", {22'd0, floor_reg}, {22'd0, model_vec()});
        repeat (10) @(negedge CLOCK_50);
        key_n        = 1'b1;
        service_done = 1'b0;
        repeat (DB + 6) @(negedge CLOCK_50);
    endtask

    task automatic check_all_zero(input string nm);
        chk(nm, {22'd0, floor_reg}, 32'd0);
        chk({nm, "_pulses"}, {30'd0, req_accept, req_reject}, 32'd0);
        chk({nm, "_hints"}, {28'd0, any_request, req_here, req_above, req_below}, 32'd0);
    endtask

    function automatic logic [NF-1:0] rand_cur();
        if ($urandom_range(0, 3) == 0) return NF'($urandom_range(0, (1 << NF) - 1));
        return NF'(1) << $urandom_range(0, NF - 1);
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t;
        repeat (3) @(negedge CLOCK_50);
        check_all_zero("reset_state");
        rst = 1'b0;
        repeat (DB + 6) @(negedge CLOCK_50);

        // Short glitches never register.
        floor_sel = 4'd5;
        repeat (5) glitch(3);
        chk("glitch_floor_reg", {22'd0, floor_reg}, 32'd0);

        press(3, 20);
        chk("press3_floor_reg", {22'd0, floor_reg}, 32'h004);

        press(0, 6);
        press(12, 6);
        chk("reject_floor_reg", {22'd0, floor_reg}, 32'h004);

        service(10'b0000000100, 3);
        press(2, 5);
        press(5, 8);
        press(10, 4);
        press(5, 6);
        check_hints(10'b0000010000);
        chk("pattern_floor_reg", {22'd0, floor_reg}, 32'h212);
        service(10'b0000010000, 50);
        chk("serviced_floor_reg", {22'd0, floor_reg}, 32'h202);
        check_hints(10'b0000010000);

        press(5, 6);
        aligned(5, 10'b0000010000);
        chk("set_wins", {31'd0, floor_reg[4]}, 32'd1);
        aligned(7, 10'b0000010000);
        chk("set_and_clear", {22'd0, floor_reg}, 32'h242);

        // Reset arrives mid-debounce with the key held; the hold must re-debounce.
        @(negedge CLOCK_50);
        floor_sel = 4'd7;
        repeat (3) @(negedge CLOCK_50);
        key_n = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        #2 rst = 1'b1;
        #1;
        for (int i = 0; i < NF; i++) pending[i] = 1'b0;
        cur_floor = '0;
        check_all_zero("async_reset");
        repeat (3) @(negedge CLOCK_50);
        rst = 1'b0;
        push_press(7);
        repeat (15) @(negedge CLOCK_50);
        key_n = 1'b1;
        repeat (DB + 6) @(negedge CLOCK_50);
        chk("post_reset_press", {22'd0, floor_reg}, 32'h040);

        for (int k = 0; k < 40; k++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4: press($urandom_range(0, 15), $urandom_range(DB, 12));
                5, 6:          glitch($urandom_range(1, DB - 1));
                7, 8:          service(rand_cur(), $urandom_range(1, 20));
                default:       check_hints(rand_cur());
            endcase
        end
        check_hints(rand_cur());

        t = 0;
        while (q.size() != 0 && t < 50) begin
            @(negedge CLOCK_50);
            t++;
        end
        chk("queue_drained", q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/floor_request_unit.md
# floor_request_unit

Upstream stage of the elevator controller: captures operator floor requests from the 4-bit floor switches when the request pushbutton is pressed and holds them in a one-hot pending-request register. It also clears a request once its floor has been serviced. The pushbutton is synchronised and debounced internally, invalid floor codes are rejected, and direction hints (above/below/here) are exported. The state controller and LED bank consume the register and hints directly.

## Interface
- NUM_FLOORS, 10, number of floors; fixed width of all one-hot vectors (supported value: 10).
- DEBOUNCE_CYCLES, 500000, consecutive CLOCK_50 cycles a changed key level must hold before it is accepted (10 ms); minimum 2.
- CLOCK_50  in  1  system clock, 50 MHz; all state updates on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- key_n  in  1  request pushbutton, active-low, raw and asynchronous.
- floor_sel  in  4  requested floor, binary 1..10; raw switches, asynchronous.
- cur_floor  in  NUM_FLOORS  current car position, one-hot (bit0 = floor 1).
- service_done  in  1  door-cycle-complete level from the busy counter; may stay high for many cycles.
- floor_reg  out  NUM_FLOORS  pending requests, bit k = floor k+1.
- req_accept  out  1  one-cycle pulse when a valid request is latched.
- req_reject  out  1  one-cycle pulse when a press carried code 0 or 11..15.
- any_request  out  1  OR of floor_reg.
- req_here  out  1  (floor_reg & cur_floor) != 0.
- req_above  out  1  some floor_reg bit set at an index strictly above the cur_floor bit.
- req_below  out  1  some floor_reg bit set at an index strictly below the cur_floor bit.

## Operation
- Input conditioning: key_n and floor_sel each pass through a 2-flop synchroniser (key_s, sel_s).
- Debounce: register key_stable (reset 1 = released) and counter db_cnt (reset 0).
  - If key_s == key_stable: db_cnt <= 0.
  - Otherwise db_cnt increments. When db_cnt == DEBOUNCE_CYCLES-1, key_stable <= key_s and db_cnt <= 0.
  - Counter width is ceil(log2(DEBOUNCE_CYCLES)); db_cnt never wraps.
- Press event: press = key_stable transitions 1->0. The release transition produces no event. Holding the key down yields exactly one event.
- Decode: on press, sel_s in 1..10 sets floor_reg[sel_s-1] and pulses req_accept. Code 0 or 11..15 pulses req_reject and leaves floor_reg unchanged. Re-requesting a floor that is already pending still pulses req_accept; floor_reg is unchanged.
- Service clear: a rising edge of service_done (registered previous value, reset 0) clears floor_reg at the set bit of cur_floor.
  - If cur_floor is not exactly one-hot, nothing is cleared.
  - A service_done held high clears only once.
- Simultaneous set and clear on the same bit: set wins (bit stays 1). Set and clear on different bits both take effect.
- Hints: any_request, req_here, req_above and req_below are combinational from floor_reg and cur_floor. If cur_floor is not one-hot, req_here/above/below are 0.
- Reset (async, any time, including mid-debounce or mid-press):
  - floor_reg = 0, req_accept = 0, req_reject = 0, key_stable = 1, db_cnt = 0, synchronisers = 1 (key) and 0 (sel), service_done history = 0.
  - A key still held at reset release must pass the full debounce as a new press before it is recognised.

## Timing
- Press latency: key_n falls at edge E0. key_s is low after E2. key_stable falls at edge E2+DEBOUNCE_CYCLES. floor_reg bit and req_accept pulse are visible one edge later.
- req_accept/req_reject are high for exactly one CLOCK_50 cycle, coincident with the first cycle the floor_reg update is visible.
- floor_sel is sampled from sel_s in the same cycle the press is detected. Switches must be stable ≥3 cycles before that edge.
- Service clear: the bit drops one edge after the first cycle service_done is seen high (after registering).
- Hints change combinationally, in the same cycle as floor_reg or cur_floor changes.
- Glitches on key_n shorter than DEBOUNCE_CYCLES cycles produce no event.

## Test plan
- Use DEBOUNCE_CYCLES=4. Hold floor_sel=3; key_n low for 20 cycles, then high -> floor_reg=10'b0000000100 exactly 7 cycles after the fall; one req_accept pulse; nothing on release.
- key_n pulses low for 3 cycles, five times, floor_sel=5 -> floor_reg stays 0; no pulses.
- floor_sel=0, then 12, each with a clean press -> two req_reject pulses; floor_reg=0.
- floor_reg=10'b1000010010, cur_floor=10'b0000010000 -> req_here=1, req_above=1, req_below=1. Then raise service_done for 50 cycles -> floor_reg=10'b1000000010 after one clear; req_here=0.
- With floor_reg bit 4 pending and cur_floor at floor 5, align a press with floor_sel=5 to the service_done rising edge -> bit 4 remains 1; req_accept pulses.
- Assert rst mid-debounce while key_n is held low, then release rst with key_n still low -> all outputs 0; a new request is latched only after the full debounce latency.
